// File: rtl/scc_bram_serializer.sv
// Reads a block of words from the shared configuration BRAM and shifts them MSB-first
// into the speckle sensor config chain, then strobes load and raises a completion interrupt.
module scc_bram_serializer #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned BRAM_LAT  = 1,
    parameter int unsigned SCLK_HALF = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy,
    output logic              done_irq,
    input  logic              irq_ack,
    output logic              err_zero,
    output logic              sen_sclk,
    output logic              sen_sdata,
    output logic              sen_load
);

    localparam int unsigned HC_W  = $clog2(2 * SCLK_HALF);
    localparam int unsigned WC_W  = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
    localparam int unsigned LC_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W);

    localparam logic [HC_W-1:0]  HC_LAST   = HC_W'(2 * SCLK_HALF - 1);
    localparam logic [HC_W-1:0]  HALF      = HC_W'(SCLK_HALF);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(BRAM_LAT - 1);
    localparam logic [LC_W-1:0]  LOAD_LAST = LC_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_LOAD,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [CNT_W-1:0]  word_idx, word_d;
    logic [CNT_W-1:0]  num_lat, num_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [HC_W-1:0]   hc, hc_d;
    logic [BIT_W-1:0]  bit_idx, bit_d;
    logic [WC_W-1:0]   wc, wc_d;
    logic [LC_W-1:0]   lc, lc_d;
    logic [ADDR_W-1:0] addr_d;
    logic              en_d, busy_d, irq_d, err_d, sclk_d, sdata_d, load_d;

    // State, datapath and output registers; every output is the registered next value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            num_lat   <= '0;
            shreg     <= '0;
            hc        <= '0;
            bit_idx   <= '0;
            wc        <= '0;
            lc        <= '0;
            bram_addr <= '0;
            bram_en   <= 1'b0;
            busy      <= 1'b0;
            done_irq  <= 1'b0;
            err_zero  <= 1'b0;
            sen_sclk  <= 1'b0;
            sen_sdata <= 1'b0;
            sen_load  <= 1'b0;
        end else begin
            state     <= state_d;
            word_idx  <= word_d;
            num_lat   <= num_d;
            shreg     <= shreg_d;
            hc        <= hc_d;
            bit_idx   <= bit_d;
            wc        <= wc_d;
            lc        <= lc_d;
            bram_addr <= addr_d;
            bram_en   <= en_d;
            busy      <= busy_d;
            done_irq  <= irq_d;
            err_zero  <= err_d;
            sen_sclk  <= sclk_d;
            sen_sdata <= sdata_d;
            sen_load  <= load_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        word_d  = word_idx;
        num_d   = num_lat;
        shreg_d = shreg;
        hc_d    = hc;
        bit_d   = bit_idx;
        wc_d    = wc;
        lc_d    = lc;
        addr_d  = bram_addr;
        en_d    = 1'b0;
        err_d   = 1'b0;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        load_d  = 1'b0;
        // A completion set in S_DONE overrides a coincident acknowledge
        irq_d   = done_irq & ~irq_ack;

        case (state)
            S_IDLE: begin
                if (start) begin
                    irq_d  = 1'b0;
                    num_d  = num_words;
                    word_d = '0;
                    addr_d = base_addr & ~ADDR_W'(3);
                    if (num_words == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        en_d    = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                wc_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wc == WAIT_LAST) begin
                    shreg_d = bram_dout;
                    sdata_d = bram_dout[DATA_W-1];
                    hc_d    = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    wc_d = wc + WC_W'(1);
                end
            end
            S_SHIFT: begin
                if (hc != HC_LAST) begin
                    hc_d    = hc + HC_W'(1);
                    sclk_d  = (hc_d >= HALF);
                    sdata_d = sen_sdata;
                end else if (bit_idx != BIT_LAST) begin
                    bit_d   = bit_idx + BIT_W'(1);
                    hc_d    = '0;
                    shreg_d = shreg << 1;
                    sdata_d = shreg_d[DATA_W-1];
                end else if (word_idx != num_lat - CNT_W'(1)) begin
                    // Address wraps modulo 2^ADDR_W by construction
                    word_d  = word_idx + CNT_W'(1);
                    addr_d  = bram_addr + ADDR_W'(4);
                    en_d    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    lc_d    = '0;
                    load_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (lc == LOAD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    lc_d   = lc + LC_W'(1);
                    load_d = 1'b1;
                end
            end
            S_DONE: begin
                irq_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_scc_bram_serializer.sv
// Scoreboard bench for scc_bram_serializer: stimulus pushes expected BRAM addresses, serial bits,
// load widths and irq latencies; a negedge monitor pops and compares as the DUT presents them.
module tb_scc_bram_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] base_addr;
    logic [9:0]  num_words;
    logic [14:0] bram_addr;
    logic        bram_en;
    logic [31:0] bram_dout;
    logic        busy;
    logic        done_irq;
    logic        irq_ack;
    logic        err_zero;
    logic        sen_sclk;
    logic        sen_sdata;
    logic        sen_load;

    scc_bram_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_dout (bram_dout),
        .busy      (busy),
        .done_irq  (done_irq),
        .irq_ack   (irq_ack),
        .err_zero  (err_zero),
        .sen_sclk  (sen_sclk),
        .sen_sdata (sen_sdata),
        .sen_load  (sen_load)
    );

    always #5 clk = ~clk;

    // One-cycle-latency BRAM port B model
    logic [31:0] mem [0:8191];
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr[14:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int start_cyc = 0;

    logic [14:0] exp_addr[$];
    bit          exp_bits[$];
    int          exp_load[$];
    int          exp_lat[$];
    int          exp_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT events against the scoreboard queues
    bit prev_sclk = 0, prev_irq = 0;
    int load_run = 0, err_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_sclk = 0;
            prev_irq  = 0;
            load_run  = 0;
            err_run   = 0;
        end else begin
            if (bram_en) begin
                if (exp_addr.size() == 0) chk("unexpected_bram_en", 32'(bram_en), 32'd0);
                else begin
                    logic [14:0] a;
                    a = exp_addr.pop_front();
                    chk("bram_addr", 32'(bram_addr), 32'(a));
                end
            end
            if (sen_sclk && !prev_sclk) begin
                if (exp_bits.size() == 0) chk("unexpected_sclk_rise", 32'(sen_sclk), 32'd0);
                else begin
                    bit b;
                    b = exp_bits.pop_front();
                    chk("sdata_bit", 32'(sen_sdata), 32'(b));
                end
            end
            if (sen_load) begin
                load_run++;
                chk("load_quiet", 32'({sen_sclk, sen_sdata}), 32'd0);
            end else if (load_run != 0) begin
                if (exp_load.size() == 0) chk("unexpected_load", 32'(load_run), 32'd0);
                else chk("load_width", 32'(load_run), 32'(exp_load.pop_front()));
                load_run = 0;
            end
            if (err_zero) err_run++;
            else if (err_run != 0) begin
                if (exp_err.size() == 0) chk("unexpected_err_zero", 32'(err_run), 32'd0);
                else chk("err_zero_width", 32'(err_run), 32'(exp_err.pop_front()));
                err_run = 0;
            end
            if (done_irq && !prev_irq) begin
                if (exp_lat.size() == 0) chk("unexpected_irq", 32'(done_irq), 32'd0);
                else chk("irq_latency", 32'(cyc - start_cyc), 32'(exp_lat.pop_front()));
            end
            prev_sclk = sen_sclk;
            prev_irq  = done_irq;
        end
    end

    task automatic load_word(input logic [14:0] addr, input logic [31:0] data);
        mem[addr[14:2]] = data;
        exp_addr.push_back(addr);
        for (int b = 31; b >= 0; b--) exp_bits.push_back(data[b]);
    endtask

    task automatic go(input logic [14:0] base, input logic [9:0] n, input int lat);
        exp_lat.push_back(lat);
        if (n == 0) exp_err.push_back(1);
        else exp_load.push_back(4);
        @(negedge clk);
        base_addr = base;
        num_words = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic finish_run(input string name);
        for (int i = 0; i < 1500; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk({name, "_timeout"}, 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk({name, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        chk({name, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
        chk({name, "_load_left"}, 32'(exp_load.size()), 32'd0);
        chk({name, "_irq_left"}, 32'(exp_lat.size()), 32'd0);
        chk({name, "_err_left"}, 32'(exp_err.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        irq_ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({bram_addr, bram_en, busy, done_irq, err_zero, sen_sclk, sen_sdata, sen_load}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word: 0xA5000001 at 0x0010
        load_word(15'h0010, 32'hA500_0001);
        go(15'h0010, 10'd1, 263);
        chk("busy_after_start", 32'(busy), 32'd1);
        finish_run("one_word");
        chk("irq_held", 32'(done_irq), 32'd1);

        // Three consecutive words
        load_word(15'h0100, 32'h1234_5678);
        load_word(15'h0104, 32'hFFFF_0000);
        load_word(15'h0108, 32'h0F0F_0F0F);
        go(15'h0100, 10'd3, 779);
        chk("start_clears_irq", 32'(done_irq), 32'd0);
        finish_run("three_words");

        // Zero words with ack in the completion cycle: set wins, next ack clears
        go(15'h0040, 10'd0, 1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_set_wins", 32'(done_irq), 32'd1);
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_ack_clear", 32'(done_irq), 32'd0);
        finish_run("zero_words");

        // Unaligned base near the top wraps to 0; start while busy is ignored
        load_word(15'h7FFC, 32'hDEAD_BEEF);
        load_word(15'h0000, 32'hC000_0003);
        go(15'h7FFE, 10'd2, 521);
        repeat (50) @(negedge clk);
        base_addr = 15'h0040;
        num_words = 10'd1;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        finish_run("wrap");

        // Reset in the middle of word 2
        load_word(15'h0200, 32'h5555_5555);
        load_word(15'h0204, 32'hAAAA_AAAA);
        load_word(15'h0208, 32'h0000_0001);
        go(15'h0200, 10'd3, 779);
        repeat (300) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({bram_addr, bram_en, busy, done_irq, err_zero, sen_sclk, sen_sdata, sen_load}), 32'd0);
        exp_addr.delete();
        exp_bits.delete();
        exp_load.delete();
        exp_lat.delete();
        exp_err.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        chk("no_irq_after_abort", 32'({busy, done_irq}), 32'd0);

        // Normal run after the abort
        load_word(15'h0200, 32'h5555_5555);
        go(15'h0200, 10'd1, 263);
        finish_run("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
